ieee_to_fixed_seq: RTL and testbench

Parametrised sequential converter from an IEEE-754-style binary float to an unsigned fixed-point magnitude (INT_W.FRAC_W) plus a sign bit.
- Generalises the 8-bit bias-127 frac_bin converter to arbitrary exponent, mantissa and output widths.
- Adds a start/busy/done handshake, synchronous reset, denormal/zero/inf/NaN handling, overflow saturation and an inexact flag.
- Sits between float-producing blocks and the fixed-point datapath; aligns one bit per clock to keep area small.

---
 rtl/ieee_fixed_pkg.sv | 42 ++++
 rtl/ieee_classify.sv | 86 ++++++++
 rtl/ieee_to_fixed_seq.sv | 159 +++++++++++++++
 tb/tb_ieee_to_fixed_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ieee_fixed_pkg.sv
// Shared types and helpers for the float-to-fixed converter.
package ieee_fixed_pkg;

  // Converter control states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASS,
    ST_SHL,
    ST_SHR,
    ST_FIN
  } state_t;

  // Outcome of classifying the accepted operand, in priority order.
  typedef enum logic [2:0] {
    ACT_NAN,
    ACT_INF,
    ACT_ZERO,
    ACT_SAT,
    ACT_UFLOW,
    ACT_SHL,
    ACT_SHR,
    ACT_DONE
  } action_t;

  // Bit position of the exponent LSB in a {sign, exp, man} word.
  function automatic int exp_lsb(input int man_w);
    return man_w;
  endfunction

  // Bit position of the sign in a {sign, exp, man} word.
  function automatic int sign_bit(input int exp_w, input int man_w);
    return exp_w + man_w;
  endfunction

  // True when the low exp_w bits of exp_field are all ones (inf/NaN encoding).
  function automatic logic exp_all_ones(input logic [31:0] exp_field, input int exp_w);
    logic [31:0] mask;
    mask = (32'd1 << exp_w) - 32'd1;
    return (exp_field & mask) == mask;
  endfunction

endpackage

// File: rtl/ieee_classify.sv
// Combinational front end: splits the operand into fields, builds the
// initial work word, and decides which path the converter takes.
module ieee_classify
  import ieee_fixed_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 16,
  parameter int BIAS   = 2**(EXP_W-1) - 1,
  parameter int CNT_W  = 5
) (
  input  logic [EXP_W+MAN_W:0]      float_in,
  output logic                      sign,
  output action_t                   action,
  output logic [CNT_W-1:0]          cnt,
  output logic [INT_W+FRAC_W-1:0]   w_init,
  output logic                      dropped
);

  localparam int EXP_LSB  = exp_lsb(MAN_W);
  localparam int SIGN_BIT = sign_bit(EXP_W, MAN_W);
  localparam logic signed [EXP_W:0] BIAS_S = (EXP_W+1)'(BIAS);
  localparam logic signed [EXP_W:0] DEN_E  = (EXP_W+1)'(1 - BIAS);

  logic [EXP_W-1:0]        exp_f;
  logic [MAN_W-1:0]        man_f;
  logic [FRAC_W-1:0]       man_al;
  logic                    hidden;
  logic                    exp_max;
  logic                    man_nz;
  logic signed [EXP_W:0]   e_eff;
  int                      e_int;

  assign sign    = float_in[SIGN_BIT];
  assign exp_f   = float_in[SIGN_BIT-1:EXP_LSB];
  assign man_f   = float_in[EXP_LSB-1:0];
  assign hidden  = |exp_f;
  assign man_nz  = |man_f;
  assign exp_max = exp_all_ones(32'(exp_f), EXP_W);

  // Mantissa is MSB-aligned directly below the hidden bit; surplus LSBs are
  // truncated and remembered as inexact, a short mantissa is zero-padded.
  generate
    if (MAN_W > FRAC_W) begin : g_trunc
      assign man_al  = man_f[MAN_W-1 -: FRAC_W];
      assign dropped = |man_f[MAN_W-FRAC_W-1:0];
    end else if (MAN_W == FRAC_W) begin : g_exact
      assign man_al  = man_f;
      assign dropped = 1'b0;
    end else begin : g_pad
      assign man_al  = {man_f, {(FRAC_W-MAN_W){1'b0}}};
      assign dropped = 1'b0;
    end
  endgenerate

  // Denormals use the fixed exponent 1-BIAS with a zero hidden bit.
  assign e_eff = hidden ? ($signed({1'b0, exp_f}) - BIAS_S) : DEN_E;
  assign e_int = int'(e_eff);

  // Priority decode of the operand class and the alignment shift count.
  always_comb begin
    w_init             = '0;
    w_init[FRAC_W:0]   = {hidden, man_al};
    cnt                = '0;
    action             = ACT_DONE;
    if (exp_max && man_nz) begin
      action = ACT_NAN;
    end else if (exp_max) begin
      action = ACT_INF;
    end else if (!hidden && !man_nz) begin
      action = ACT_ZERO;
    end else if (e_int >= INT_W) begin
      action = ACT_SAT;
    end else if (-e_int > FRAC_W) begin
      action = ACT_UFLOW;
    end else if (e_int > 0) begin
      action = ACT_SHL;
      cnt    = CNT_W'(e_int);
    end else if (e_int < 0) begin
      action = ACT_SHR;
      cnt    = CNT_W'(-e_int);
    end
  end

endmodule

// File: rtl/ieee_to_fixed_seq.sv
// Sequential float-to-fixed converter: classifies the operand, then aligns
// the work word one bit per clock and publishes INT_W.FRAC_W magnitude + sign.
//
// Handshake: start is accepted on a rising edge only while busy=0 (state
// IDLE); float_in is captured on that edge. busy stays high until the cycle
// in which done pulses for exactly one clock; the result outputs are valid
// from that cycle and hold until the next conversion completes. A start
// seen while busy is dropped, and a start during the done cycle is accepted.
module ieee_to_fixed_seq
  import ieee_fixed_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 16,
  parameter int BIAS   = 2**(EXP_W-1) - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   float_in,
  output logic                   busy,
  output logic                   done,
  output logic                   sign_out,
  output logic [INT_W-1:0]       int_part,
  output logic [FRAC_W-1:0]      frac_part,
  output logic                   ovf,
  output logic                   inexact,
  output logic                   nan
);

  localparam int WW    = INT_W + FRAC_W;
  localparam int CNT_W = $clog2(((INT_W > FRAC_W) ? INT_W : FRAC_W) + 1);

  state_t               state, state_nxt;
  logic [EXP_W+MAN_W:0] float_r;
  logic [WW-1:0]        w_r, w_nxt;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt;
  logic                 inx_r, inx_nxt;
  logic                 nan_r, nan_nxt;
  logic                 ovf_r, ovf_nxt;

  logic                 c_sign;
  action_t              c_action;
  logic [CNT_W-1:0]     c_cnt;
  logic [WW-1:0]        c_w;
  logic                 c_dropped;

  ieee_classify #(
    .EXP_W  (EXP_W),
    .MAN_W  (MAN_W),
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W),
    .BIAS   (BIAS),
    .CNT_W  (CNT_W)
  ) u_classify (
    .float_in (float_r),
    .sign     (c_sign),
    .action   (c_action),
    .cnt      (c_cnt),
    .w_init   (c_w),
    .dropped  (c_dropped)
  );

  assign busy = (state != ST_IDLE);

  // Next-state and work-register update for classify and the shift loops.
  always_comb begin
    state_nxt = state;
    w_nxt     = w_r;
    cnt_nxt   = cnt_r;
    inx_nxt   = inx_r;
    nan_nxt   = nan_r;
    ovf_nxt   = ovf_r;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLASS;
      end
      ST_CLASS: begin
        w_nxt     = c_w;
        cnt_nxt   = c_cnt;
        inx_nxt   = c_dropped;
        nan_nxt   = 1'b0;
        ovf_nxt   = 1'b0;
        state_nxt = ST_FIN;
        case (c_action)
          ACT_NAN: begin
            nan_nxt = 1'b1;
            w_nxt   = '0;
          end
          ACT_INF, ACT_SAT: begin
            ovf_nxt = 1'b1;
            w_nxt   = '1;
          end
          ACT_ZERO:  w_nxt = '0;
          ACT_UFLOW: begin
            w_nxt   = '0;
            inx_nxt = 1'b1;
          end
          ACT_SHL:   state_nxt = ST_SHL;
          ACT_SHR:   state_nxt = ST_SHR;
          ACT_DONE:  state_nxt = ST_FIN;
          default:   state_nxt = ST_FIN;
        endcase
      end
      ST_SHL: begin
        w_nxt   = w_r << 1;
        cnt_nxt = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) state_nxt = ST_FIN;
      end
      ST_SHR: begin
        inx_nxt = inx_r | w_r[0];
        w_nxt   = w_r >> 1;
        cnt_nxt = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, work registers and the result registers published from FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      float_r   <= '0;
      w_r       <= '0;
      cnt_r     <= '0;
      inx_r     <= 1'b0;
      nan_r     <= 1'b0;
      ovf_r     <= 1'b0;
      done      <= 1'b0;
      sign_out  <= 1'b0;
      int_part  <= '0;
      frac_part <= '0;
      ovf       <= 1'b0;
      inexact   <= 1'b0;
      nan       <= 1'b0;
    end else begin
      state <= state_nxt;
      w_r   <= w_nxt;
      cnt_r <= cnt_nxt;
      inx_r <= inx_nxt;
      nan_r <= nan_nxt;
      ovf_r <= ovf_nxt;
      if (state == ST_IDLE && start) float_r <= float_in;
      done <= (state == ST_FIN);
      if (state == ST_FIN) begin
        sign_out  <= c_sign;
        int_part  <= w_r[WW-1:FRAC_W];
        frac_part <= w_r[FRAC_W-1:0];
        ovf       <= ovf_r;
        inexact   <= inx_r;
        nan       <= nan_r;
      end
    end
  end

endmodule

// File: tb/tb_ieee_to_fixed_seq.sv
// Directed bench for ieee_to_fixed_seq with default widths (8/23 -> 16.16).
module tb_ieee_to_fixed_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] float_in;
  logic        busy;
  logic        done;
  logic        sign_out;
  logic [15:0] int_part;
  logic [15:0] frac_part;
  logic        ovf;
  logic        inexact;
  logic        nan;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] f;
    logic [15:0] ip;
    logic [15:0] fp;
    logic        s;
    logic        o;
    logic        x;
    logic        n;
    int          lat;
  } vec_t;

  vec_t vecs [15];

  ieee_to_fixed_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .float_in  (float_in),
    .busy      (busy),
    .done      (done),
    .sign_out  (sign_out),
    .int_part  (int_part),
    .frac_part (frac_part),
    .ovf       (ovf),
    .inexact   (inexact),
    .nan       (nan)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; the next posedge accepts the operand.
  task automatic start_op(input logic [31:0] f);
    start    = 1'b1;
    float_in = f;
    @(posedge clk);
    #1;
    start    = 1'b0;
    float_in = '0;
  endtask

  // Counts edges until done is seen high; -1 if it never arrives.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Counts done pulses over a window of cycles.
  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  initial begin
    int lat;
    int pulses;

    //                f             int       frac      s     o     x     n     lat
    vecs[0]  = '{32'h40B80000, 16'h0005, 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    vecs[1]  = '{32'h3F800000, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[2]  = '{32'hBEC00000, 16'h0000, 16'h6000, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    vecs[3]  = '{32'h3F800001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[4]  = '{32'h4788B800, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[5]  = '{32'h7F800000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[6]  = '{32'h7FC00000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    vecs[7]  = '{32'h00000001, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[8]  = '{32'h80000000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[9]  = '{32'h37800000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 18};
    vecs[10] = '{32'h37000000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[11] = '{32'h477FFF80, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    vecs[12] = '{32'h3E800080, 16'h0000, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 4};
    vecs[13] = '{32'h46000000, 16'h2000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 15};
    vecs[14] = '{32'hC788B800, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 2};

    // Reset block.
    rst      = 1'b1;
    start    = 1'b0;
    float_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, sign_out, ovf, inexact, nan, int_part, frac_part}, 64'd0);
    rst = 1'b0;

    // Table-driven conversions.
    for (int i = 0; i < 15; i++) begin
      start_op(vecs[i].f);
      check($sformatf("v%0d busy", i), busy, 1'b1);
      wait_done(lat);
      check($sformatf("v%0d lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d int", i), int_part, vecs[i].ip);
      check($sformatf("v%0d frac", i), frac_part, vecs[i].fp);
      check($sformatf("v%0d flags", i), {sign_out, ovf, inexact, nan},
            {vecs[i].s, vecs[i].o, vecs[i].x, vecs[i].n});
      check($sformatf("v%0d busy_done", i), busy, 1'b0);
    end

    // Start while busy is ignored; start on the done cycle is accepted.
    start_op(32'h40B80000);
    @(posedge clk);
    #1;
    start    = 1'b1;
    float_in = 32'h3F800000;
    @(posedge clk);
    #1;
    start    = 1'b0;
    float_in = '0;
    wait_done(lat);
    check("hs_ignored lat", (lat < 0) ? lat : lat + 2, 4);
    check("hs_ignored result", {int_part, frac_part}, {16'h0005, 16'hC000});
    check("hs_done_cycle busy", busy, 1'b0);
    start_op(32'h3F800000);
    wait_done(lat);
    check("hs_b2b lat", lat, 2);
    check("hs_b2b result", {int_part, frac_part}, {16'h0001, 16'h0000});
    count_done(6, pulses);
    check("hs_no_queue done", pulses, 0);
    check("hs_no_queue busy", busy, 1'b0);

    // Reset in the middle of the left-shift loop.
    start_op(32'h46000000);
    repeat (4) @(posedge clk);
    #1;
    check("mid_reset busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_reset outputs", {busy, done, sign_out, ovf, inexact, nan, int_part, frac_part}, 64'd0);
    count_done(20, pulses);
    check("mid_reset no_done", pulses, 0);
    start_op(32'h46000000);
    wait_done(lat);
    check("post_reset lat", lat, 15);
    check("post_reset result", {int_part, frac_part}, {16'h2000, 16'h0000});

    // Reset wins over a simultaneous start.
    rst      = 1'b1;
    start    = 1'b1;
    float_in = 32'h40B80000;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    start    = 1'b0;
    float_in = '0;
    check("rst_vs_start busy", busy, 1'b0);
    count_done(6, pulses);
    check("rst_vs_start no_done", pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
